// File: rtl/mult_div_ctrl.sv
// Iterative 32-bit unsigned multiply/divide sequencer that borrows a shared
// external adder/subtractor for one shift-add or shift-subtract step per cycle.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] ALU_ADD  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [4:0] LAST_CNT = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [4:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic             op_reg, op_next;

    // Divide step: partial remainder shifted left with the next dividend bit.
    logic [WIDTH-1:0] div_shift;
    assign div_shift = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            d_reg     <= '0;
            op_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            d_reg     <= d_next;
            op_reg    <= op_next;
        end
    end

    // ALU drive kept apart from the datapath update so the round trip through
    // the external ALU is never seen as a loop inside one block.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        if (state_reg == RUN) begin
            if (op_reg) begin
                alu_op = ALU_SUB;
                alu_a  = div_shift;
                alu_b  = d_reg;
            end else begin
                alu_op = ALU_ADD;
                alu_a  = hi_reg;
                alu_b  = lo_reg[0] ? d_reg : '0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        d_next     = d_reg;
        op_next    = op_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next  = op;
                    cnt_next = '0;
                    if (op && (b == '0)) begin
                        d_next     = b;
                        hi_next    = a;
                        lo_next    = '1;
                        state_next = DONE;
                    end else begin
                        d_next     = op ? b : a;
                        hi_next    = '0;
                        lo_next    = op ? a : b;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (op_reg) begin
                    // Restoring division; a set hi[31] means the shifted
                    // remainder is 33 bits wide and must exceed the divisor.
                    if (hi_reg[WIDTH-1] || alu_cout) begin
                        hi_next = alu_result;
                        lo_next = {lo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_next = div_shift;
                        lo_next = {lo_reg[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_next = {alu_cout, alu_result[WIDTH-1:1]};
                    lo_next = {alu_result[0], lo_reg[WIDTH-1:1]};
                end
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: supplies the shared ALU, runs directed and random
// operations, and checks every cycle against a transaction-level model.
module tb_mult_div_ctrl;

    localparam logic [2:0] ADD = 3'b101;
    localparam logic [2:0] SUB = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_cout;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Shared ALU: for SUB the carry is 1 when no borrow occurs.
    always_comb begin
        if (alu_op == SUB)
            {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else
            {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an operation occupies 32 busy cycles and then
    // one done cycle; the result comes straight from * / and %.
    logic        m_busy, m_done, m_valid, m_op;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;
    int          m_ndone = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_valid = 1; m_op = 0;
            m_hi = 0; m_lo = 0; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_valid = 1;
                m_hi = p_hi; m_lo = p_lo; m_ndone++;
                $display("txn op=%0d hi=%h lo=%h", m_op, m_hi, m_lo);
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            m_op = op;
            if (op) begin
                if (b == 0) begin p_hi = a; p_lo = 32'hFFFF_FFFF; end
                else begin p_hi = a % b; p_lo = a / b; end
            end else begin
                {p_hi, p_lo} = {32'd0, a} * {32'd0, b};
            end
            if (op && b == 0) begin
                m_done = 1; m_hi = p_hi; m_lo = p_lo; m_ndone++;
                $display("txn op=1 divide-by-zero hi=%h lo=%h", m_hi, m_lo);
            end else begin
                m_busy = 1; m_left = 32; m_valid = 0;
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("done", {63'd0, done}, {63'd0, m_done});
            if (m_valid) chk("hilo", {hi, lo}, {m_hi, m_lo});
            if (m_busy) begin
                chk("alu_op_run", {61'd0, alu_op}, {61'd0, (m_op ? SUB : ADD)});
            end else begin
                chk("alu_op_idle", {61'd0, alu_op}, {61'd0, ADD});
                chk("alu_ab_idle", {alu_a, alu_b}, 64'd0);
            end
        end
    end

    task automatic run_op(input logic o, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ebusy);
        int  busy_cnt;
        bit  seen;
        busy_cnt = 0;
        seen = 0;
        @(posedge clk); #2;
        start = 1; op = o; a = ta; b = tb_v;
        @(posedge clk); #2;
        start = 0; a = $urandom; b = $urandom;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) seen = 1;
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        chk("busy_cycles", 64'(busy_cnt), 64'(ebusy));
        chk("result_lit", {hi, lo}, {ehi, elo});
        chk("model_pin", {m_hi, m_lo}, {ehi, elo});
    endtask

    task automatic drain();
        start = 0;
        repeat (40) @(posedge clk);
        #2;
    endtask

    initial begin
        int ndone;
        int base;
        rst_n = 0; start = 1; op = 0; a = 32'd6; b = 32'd7;
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        cmp_en = 1;
        // First edge after reset release must take the pending start.
        @(posedge clk); #2;
        start = 0;
        @(negedge clk);
        chk("first_accept", {63'd0, busy}, 64'd1);
        repeat (40) @(negedge clk);
        chk("first_result", {hi, lo}, {32'd0, 32'd42});

        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32);
        run_op(1, 32'd100, 32'd7, 32'd2, 32'd14, 32);
        run_op(1, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 32);
        run_op(1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
        run_op(0, 32'd3, 32'd4, 32'd0, 32'd12, 32);

        // Start held high: a new operation only every 34 cycles.
        @(posedge clk); #2;
        start = 1; op = 0; a = 32'd3; b = 32'd4;
        ndone = 0;
        repeat (102) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("held_result", {hi, lo}, {32'd0, 32'd12});
            end
        end
        chk("held_done_count", 64'(ndone), 64'd3);
        @(posedge clk); #2;
        drain();

        // Reset in the middle of a multiply.
        start = 1; op = 0; a = $urandom; b = $urandom;
        @(posedge clk); #2;
        start = 0;
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        chk("midreset_hilo", {hi, lo}, 64'd0);
        chk("midreset_alu", {alu_a, alu_b}, 64'd0);
        @(negedge clk); #2 rst_n = 1;
        base = m_ndone;
        repeat (5) begin
            @(negedge clk);
            chk("midreset_nodone", {63'd0, done}, 64'd0);
        end
        chk("midreset_model_nodone", 64'(m_ndone - base), 64'd0);
        run_op(1, 32'd100, 32'd7, 32'd2, 32'd14, 32);

        // Random traffic, including starts during RUN/DONE and zero divisors.
        base = m_ndone;
        repeat (3000) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 1);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        end
        drain();
        chk("random_activity", 64'(m_ndone - base > 20), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
